// File: rtl/noc_packetizer.sv
// noc_packetizer: turns a packet request (payload chunks, destination, VC)
// into one head flit followed by N data flits written to an elastic FIFO.
// The FIFO write side may stall via i_fifo_ready; no flit is lost or repeated.
module noc_packetizer #(
  parameter int WIDTH     = 16,
  parameter int NUM_FLITS = 4,
  parameter int DEST_W    = 4
) (
  input  logic                                  write_clk,
  input  logic                                  rst,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [NUM_FLITS*(WIDTH-4)-1:0]        i_data,
  input  logic [$clog2(NUM_FLITS+1)-1:0]        i_num_flits,
  input  logic [DEST_W-1:0]                     i_dest,
  input  logic                                  i_vc,
  output logic [WIDTH-1:0]                      o_fifo_data,
  output logic                                  o_fifo_write_en,
  input  logic                                  i_fifo_ready,
  output logic [15:0]                           o_pkt_count
);

  localparam int PW = WIDTH - 4;
  localparam int CW = $clog2(NUM_FLITS + 1);

  localparam logic IDLE = 1'b0;
  localparam logic SEND = 1'b1;

  localparam logic [CW-1:0] MAX_N = CW'(NUM_FLITS);
  localparam logic [CW-1:0] ONE_N = CW'(1);

  logic                     state_reg;
  logic [CW-1:0]            idx_reg;     // 0 = head flit, k = data flit k-1
  logic [CW-1:0]            num_reg;     // effective data flit count
  logic [NUM_FLITS*PW-1:0]  data_reg;
  logic [DEST_W-1:0]        dest_reg;
  logic                     vc_reg;
  logic [15:0]              pkt_count_reg;

  logic [CW-1:0]            eff_num;
  logic [PW-1:0]            chunk [NUM_FLITS];
  logic [PW-1:0]            chunk_cur;
  logic [WIDTH-1:0]         flit;
  logic                     write_en;

  // Split the latched payload into per-flit chunks
  generate
    for (genvar gi = 0; gi < NUM_FLITS; gi++) begin : g_chunk
      assign chunk[gi] = data_reg[gi*PW +: PW];
    end
  endgenerate

  // Clamp the requested flit count into 1..NUM_FLITS
  always_comb begin
    eff_num = i_num_flits;
    if (i_num_flits == '0) begin
      eff_num = ONE_N;
    end else if (i_num_flits > MAX_N) begin
      eff_num = MAX_N;
    end
  end

  // Select the payload chunk for the data flit currently being presented
  always_comb begin
    chunk_cur = '0;
    for (int k = 0; k < NUM_FLITS; k++) begin
      if (idx_reg == CW'(k + 1)) begin
        chunk_cur = chunk[k];
      end
    end
  end

  // Build the current flit; all zeros when idle or held in reset
  always_comb begin
    flit = '0;
    if (rst && (state_reg == SEND)) begin
      if (idx_reg == '0) begin
        flit = {1'b1, 1'b1, 1'b0, vc_reg, PW'(dest_reg)};
      end else begin
        flit = {1'b1, 1'b0, (idx_reg == num_reg), vc_reg, chunk_cur};
      end
    end
  end

  assign write_en        = rst & (state_reg == SEND) & i_fifo_ready;
  assign o_fifo_write_en = write_en;
  assign o_fifo_data     = flit;
  assign o_ready         = rst & (state_reg == IDLE);
  assign o_pkt_count     = pkt_count_reg;

  // Accept a request in IDLE, then walk head + data flits, advancing only on writes
  always_ff @(posedge write_clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      num_reg       <= '0;
      data_reg      <= '0;
      dest_reg      <= '0;
      vc_reg        <= 1'b0;
      pkt_count_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (i_valid) begin
        state_reg <= SEND;
        idx_reg   <= '0;
        num_reg   <= eff_num;
        data_reg  <= i_data;
        dest_reg  <= i_dest;
        vc_reg    <= i_vc;
      end
    end else if (i_fifo_ready) begin
      if (idx_reg == num_reg) begin
        state_reg     <= IDLE;
        idx_reg       <= '0;
        pkt_count_reg <= pkt_count_reg + 16'd1;
      end else begin
        idx_reg <= idx_reg + ONE_N;
      end
    end
  end

endmodule

// File: tb/tb_noc_packetizer.sv
// tb_noc_packetizer: scenario tasks drive noc_packetizer and compare the
// written flit stream against a packet-level reference model.
module tb_noc_packetizer;

  localparam int WIDTH     = 16;
  localparam int NUM_FLITS = 4;
  localparam int DEST_W    = 4;
  localparam int PW        = WIDTH - 4;
  localparam int CW        = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    i_valid = 1'b0;
  logic                    o_ready;
  logic [NUM_FLITS*PW-1:0] i_data = '0;
  logic [CW-1:0]           i_num_flits = '0;
  logic [DEST_W-1:0]       i_dest = '0;
  logic                    i_vc = 1'b0;
  logic [WIDTH-1:0]        o_fifo_data;
  logic                    o_fifo_write_en;
  logic                    i_fifo_ready = 1'b0;
  logic [15:0]             o_pkt_count;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          got_cyc[$];
  logic        stall_we_q[$];
  logic [15:0] stall_dat_q[$];
  logic [15:0] exp_count = '0;
  bit          timed_out;
  bit          ready_in_send;

  noc_packetizer #(.WIDTH(WIDTH), .NUM_FLITS(NUM_FLITS), .DEST_W(DEST_W)) dut (
    .write_clk       (clk),
    .rst             (rst),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_data          (i_data),
    .i_num_flits     (i_num_flits),
    .i_dest          (i_dest),
    .i_vc            (i_vc),
    .o_fifo_data     (o_fifo_data),
    .o_fifo_write_en (o_fifo_write_en),
    .i_fifo_ready    (i_fifo_ready),
    .o_pkt_count     (o_pkt_count)
  );

  always #5 clk = ~clk;

  function automatic logic [NUM_FLITS*PW-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[NUM_FLITS*PW-1:0];
  endfunction

  // Reference: the flit list a packet request must produce
  task automatic model_packet(input logic [NUM_FLITS*PW-1:0] data, input int nf,
                              input logic [DEST_W-1:0] dest, input logic vc);
    int n;
    n = (nf == 0) ? 1 : ((nf > NUM_FLITS) ? NUM_FLITS : nf);
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b1, 1'b0, vc, 8'h00, dest});
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({1'b1, 1'b0, (k == n - 1), vc, data[k*PW +: PW]});
    end
  endtask

  // Issue one request and capture every FIFO write up to the tail flit
  task automatic drive_packet(input logic [NUM_FLITS*PW-1:0] data, input logic [CW-1:0] nf,
                              input logic [DEST_W-1:0] dest, input logic vc,
                              input int stall_from, input int stall_len, input bit rnd);
    int t;
    int cyc;
    got_q.delete();
    got_cyc.delete();
    stall_we_q.delete();
    stall_dat_q.delete();
    timed_out = 1'b0;
    ready_in_send = 1'b0;
    @(negedge clk);
    i_valid = 1'b1; i_data = data; i_num_flits = nf; i_dest = dest; i_vc = vc;
    i_fifo_ready = 1'b1;
    #1;
    t = 0;
    while (o_ready !== 1'b1 && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 50) begin
      timed_out = 1'b1;
      i_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // scramble request inputs after accept: the DUT must use its latched copy
    i_valid = 1'b0;
    i_data = rand_data();
    i_num_flits = CW'($urandom_range(0, 7));
    i_dest = DEST_W'($urandom());
    i_vc = ~vc;
    cyc = 0;
    while (cyc < 100) begin
      if (rnd) i_fifo_ready = ($urandom_range(0, 2) != 0);
      else     i_fifo_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      #1;
      if (o_ready) ready_in_send = 1'b1;
      if (!i_fifo_ready) begin
        stall_we_q.push_back(o_fifo_write_en);
        stall_dat_q.push_back(o_fifo_data);
      end
      if (o_fifo_write_en) begin
        got_q.push_back(o_fifo_data);
        got_cyc.push_back(cyc);
        if (o_fifo_data[WIDTH-3]) break;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) timed_out = 1'b1;
    i_fifo_ready = 1'b1;
  endtask

  task automatic test_reset();
    i_valid = 1'b1; i_fifo_ready = 1'b1; i_num_flits = 3'd2; rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      vectors++;
      if ({o_ready, o_fifo_write_en, o_fifo_data} !== {1'b0, 1'b0, 16'h0000}) begin
        miscompares++;
        $display("FAIL reset_outputs: got rdy=%b we=%b data=%h required rdy=0 we=0 data=0000",
                 o_ready, o_fifo_write_en, o_fifo_data);
      end
    end
    vectors++;
    if (o_pkt_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_count: got %h required 0000", o_pkt_count);
    end
    @(negedge clk);
    i_valid = 1'b0; rst = 1'b1;
    #1;
    vectors++;
    if ({o_ready, o_fifo_write_en, o_fifo_data} !== {1'b1, 1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_release: got rdy=%b we=%b data=%h required rdy=1 we=0 data=0000",
               o_ready, o_fifo_write_en, o_fifo_data);
    end
    exp_count = '0;
  endtask

  task automatic test_single();
    logic [15:0] req [3];
    req[0] = 16'hD003; req[1] = 16'h9ABC; req[2] = 16'hB123;
    drive_packet({24'h0, 12'h123, 12'hABC}, 3'd2, 4'h3, 1'b1, 0, 0, 1'b0);
    exp_count++;
    vectors++;
    if (timed_out !== 1'b0 || got_q.size() != 3) begin
      miscompares++;
      $display("FAIL single_len: got %0d writes (timeout=%b) required 3", got_q.size(), timed_out);
    end
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== req[k]) begin
        miscompares++;
        $display("FAIL single_flit%0d: got %h required %h", k, got_q[k], req[k]);
      end
    end
    if (got_cyc.size() == 3) begin
      vectors++;
      if (got_cyc[0] != 0 || got_cyc[2] != 2) begin
        miscompares++;
        $display("FAIL single_timing: got cycles %0d..%0d required 0..2", got_cyc[0], got_cyc[2]);
      end
    end
    @(negedge clk); #1;
    vectors++;
    if ({o_ready, o_fifo_write_en, o_fifo_data, o_pkt_count} !== {1'b1, 1'b0, 16'h0000, exp_count}) begin
      miscompares++;
      $display("FAIL single_idle: got rdy=%b we=%b data=%h cnt=%h required 1 0 0000 %h",
               o_ready, o_fifo_write_en, o_fifo_data, o_pkt_count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    logic [NUM_FLITS*PW-1:0] d;
    logic [DEST_W-1:0]       dest;
    d = rand_data();
    dest = DEST_W'($urandom());
    model_packet(d, 4, dest, 1'b0);
    drive_packet(d, 3'd4, dest, 1'b0, 2, 3, 1'b0);
    exp_count++;
    vectors++;
    if (timed_out !== 1'b0 || got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL bp_len: got %0d writes (timeout=%b) required %0d", got_q.size(), timed_out, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL bp_flit%0d: got %h required %h", k, got_q[k], exp_q[k]);
      end
    end
    vectors++;
    if (stall_we_q.size() != 3) begin
      miscompares++;
      $display("FAIL bp_stall_len: got %0d stalled cycles required 3", stall_we_q.size());
    end
    for (int k = 0; k < stall_we_q.size(); k++) begin
      vectors++;
      if (stall_we_q[k] !== 1'b0 || stall_dat_q[k] !== exp_q[2]) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got we=%b data=%h required we=0 data=%h",
                 k, stall_we_q[k], stall_dat_q[k], exp_q[2]);
      end
    end
    @(negedge clk); #1;
    vectors++;
    if ({o_ready, o_fifo_write_en, o_pkt_count} !== {1'b1, 1'b0, exp_count}) begin
      miscompares++;
      $display("FAIL bp_idle: got rdy=%b we=%b cnt=%h required 1 0 %h",
               o_ready, o_fifo_write_en, o_pkt_count, exp_count);
    end
  endtask

  task automatic test_clamp();
    int nfs [2];
    logic [NUM_FLITS*PW-1:0] d;
    nfs[0] = 0; nfs[1] = 7;
    for (int c = 0; c < 2; c++) begin
      d = rand_data();
      model_packet(d, nfs[c], 4'h9, 1'b1);
      drive_packet(d, CW'(nfs[c]), 4'h9, 1'b1, 0, 0, 1'b0);
      exp_count++;
      vectors++;
      if (timed_out !== 1'b0 || got_q.size() != ((nfs[c] == 0) ? 2 : 5)) begin
        miscompares++;
        $display("FAIL clamp_len nf=%0d: got %0d writes (timeout=%b) required %0d",
                 nfs[c], got_q.size(), timed_out, (nfs[c] == 0) ? 2 : 5);
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        vectors++;
        if (got_q[k] !== exp_q[k]) begin
          miscompares++;
          $display("FAIL clamp nf=%0d flit%0d: got %h required %h", nfs[c], k, got_q[k], exp_q[k]);
        end
      end
      @(negedge clk); #1;
      vectors++;
      if ({o_ready, o_fifo_write_en, o_pkt_count} !== {1'b1, 1'b0, exp_count}) begin
        miscompares++;
        $display("FAIL clamp_idle nf=%0d: got rdy=%b we=%b cnt=%h required 1 0 %h",
                 nfs[c], o_ready, o_fifo_write_en, o_pkt_count, exp_count);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_r [7];
    logic exp_w [7];
    logic [NUM_FLITS*PW-1:0] d;
    int acc;
    int wi;
    exp_r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_w = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    d = rand_data();
    model_packet(d, 1, 4'h5, 1'b0);
    @(negedge clk);
    i_valid = 1'b1; i_data = d; i_num_flits = 3'd1; i_dest = 4'h5; i_vc = 1'b0; i_fifo_ready = 1'b1;
    #1;
    acc = 0; wi = 0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin
        @(negedge clk); #1;
      end
      vectors++;
      if (o_ready !== exp_r[c] || o_fifo_write_en !== exp_w[c]) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: got rdy=%b we=%b required rdy=%b we=%b",
                 c, o_ready, o_fifo_write_en, exp_r[c], exp_w[c]);
      end
      if (o_fifo_write_en) begin
        vectors++;
        if (o_fifo_data !== exp_q[wi % 2]) begin
          miscompares++;
          $display("FAIL b2b_flit%0d: got %h required %h", wi, o_fifo_data, exp_q[wi % 2]);
        end
        wi++;
      end
      if (o_ready && i_valid) acc++;
      if (acc == 2 && !o_ready) i_valid = 1'b0;
    end
    i_valid = 1'b0;
    exp_count = exp_count + 16'd2;
    vectors++;
    if (o_pkt_count !== exp_count) begin
      miscompares++;
      $display("FAIL b2b_count: got %h required %h", o_pkt_count, exp_count);
    end
  endtask

  task automatic test_random();
    logic [NUM_FLITS*PW-1:0] d;
    logic [CW-1:0]           nf;
    logic [DEST_W-1:0]       dest;
    logic                    vc;
    for (int p = 0; p < 25; p++) begin
      d = rand_data();
      nf = CW'($urandom_range(0, 7));
      dest = DEST_W'($urandom());
      vc = 1'($urandom());
      model_packet(d, int'(nf), dest, vc);
      drive_packet(d, nf, dest, vc, 0, 0, 1'b1);
      exp_count++;
      vectors++;
      if (timed_out !== 1'b0 || got_q.size() != exp_q.size() || ready_in_send !== 1'b0) begin
        miscompares++;
        $display("FAIL rand%0d_len: got %0d writes (timeout=%b rdy_in_send=%b) required %0d",
                 p, got_q.size(), timed_out, ready_in_send, exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        vectors++;
        if (got_q[k] !== exp_q[k]) begin
          miscompares++;
          $display("FAIL rand%0d_flit%0d: got %h required %h", p, k, got_q[k], exp_q[k]);
        end
      end
      for (int k = 0; k < stall_we_q.size(); k++) begin
        vectors++;
        if (stall_we_q[k] !== 1'b0) begin
          miscompares++;
          $display("FAIL rand%0d_stall%0d: got we=%b required 0", p, k, stall_we_q[k]);
        end
      end
      @(negedge clk); #1;
      vectors++;
      if ({o_ready, o_fifo_write_en, o_fifo_data, o_pkt_count} !== {1'b1, 1'b0, 16'h0000, exp_count}) begin
        miscompares++;
        $display("FAIL rand%0d_idle: got rdy=%b we=%b data=%h cnt=%h required 1 0 0000 %h",
                 p, o_ready, o_fifo_write_en, o_fifo_data, o_pkt_count, exp_count);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    @(negedge clk);
    i_valid = 1'b1; i_data = rand_data(); i_num_flits = 3'd4; i_dest = 4'hA; i_vc = 1'b1;
    i_fifo_ready = 1'b1;
    #1;
    t = 0;
    while (o_ready !== 1'b1 && t < 50) begin
      @(negedge clk); #1; t++;
    end
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    vectors++;
    if (o_fifo_write_en !== 1'b1 || o_fifo_data[WIDTH-2] !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_head: got we=%b data=%h required we=1 head flit", o_fifo_write_en, o_fifo_data);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if ({o_ready, o_fifo_write_en, o_fifo_data} !== {1'b0, 1'b0, 16'h0000}) begin
        miscompares++;
        $display("FAIL rmid_in_reset%0d: got rdy=%b we=%b data=%h required 0 0 0000",
                 c, o_ready, o_fifo_write_en, o_fifo_data);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    exp_count = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      vectors++;
      if ({o_ready, o_fifo_write_en, o_pkt_count} !== {1'b1, 1'b0, exp_count}) begin
        miscompares++;
        $display("FAIL rmid_after%0d: got rdy=%b we=%b cnt=%h required 1 0 %h",
                 c, o_ready, o_fifo_write_en, o_pkt_count, exp_count);
      end
    end
  endtask

  task automatic test_wrap();
    logic [NUM_FLITS*PW-1:0] d;
    @(negedge clk);
    force dut.pkt_count_reg = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_count_reg;
    #1;
    exp_count = 16'hFFFF;
    vectors++;
    if (o_pkt_count !== exp_count) begin
      miscompares++;
      $display("FAIL wrap_preload: got %h required %h", o_pkt_count, exp_count);
    end
    d = rand_data();
    model_packet(d, 3, 4'h7, 1'b0);
    drive_packet(d, 3'd3, 4'h7, 1'b0, 0, 0, 1'b0);
    exp_count++;
    vectors++;
    if (timed_out !== 1'b0 || got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL wrap_len: got %0d writes (timeout=%b) required %0d", got_q.size(), timed_out, exp_q.size());
    end
    @(negedge clk); #1;
    vectors++;
    if (o_pkt_count !== exp_count) begin
      miscompares++;
      $display("FAIL wrap_count: got %h required %h", o_pkt_count, exp_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_clamp();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
